// File: rtl/gmii2fifo_wide.sv
// GMII receive packer: registers the RX pins, packs frame bytes into NBYTES-lane FIFO
// words ({valid, data} per lane, first byte in the top lane) and follows each frame with Gap zero words.
module gmii2fifo_wide #(
  parameter int unsigned NBYTES         = 8,
  parameter logic [3:0]  Gap            = 4'h2,
  parameter bit          STRIP_PREAMBLE = 1'b0,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                gmii_rx_clk,
  input  logic                sys_rst,
  input  logic                gmii_rx_dv,
  input  logic                gmii_rx_er,
  input  logic [7:0]          gmii_rxd,
  input  logic                full,
  output logic [9*NBYTES-1:0] din,
  output logic                wr_en,
  output logic                wr_clk,
  output logic [CNT_W-1:0]    frame_cnt,
  output logic [CNT_W-1:0]    drop_cnt
);
  localparam int unsigned   W         = 9 * NBYTES;
  localparam int unsigned   LW        = $clog2(NBYTES);
  localparam logic [LW-1:0] LAST_LANE = LW'(NBYTES - 1);

  typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, GAP, DROP} state_e;

  state_e           state_q;
  state_e           end_state;
  logic             dv_q, er_q, dv_prev_q, smp_valid_q;
  logic [7:0]       rxd_q;
  logic [LW-1:0]    lane_q;
  logic [W-1:0]     word_q, word_d, din_q;
  logic             wr_en_q, seen_q;
  logic [3:0]       gap_q;
  logic [CNT_W-1:0] frame_q, drop_q;
  logic             frame_start;

  assign wr_clk    = gmii_rx_clk;
  assign din       = din_q;
  assign wr_en     = wr_en_q;
  assign frame_cnt = frame_q;
  assign drop_cnt  = drop_q;

  assign frame_start = dv_q & ~dv_prev_q;
  assign end_state   = (Gap == 4'd0) ? IDLE : GAP;

  // Current word with the registered byte dropped into lane NBYTES-1-lane_q.
  always_comb begin
    // NOTE: every always_comb output gets a full default first, so no latch can be inferred.
    word_d = word_q;
    for (int i = 0; i < NBYTES; i++) begin
      if (lane_q == LW'(NBYTES - 1 - i)) word_d[9*i +: 9] = {1'b1, rxd_q};
    end
  end

  always_ff @(posedge gmii_rx_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      dv_q        <= 1'b0;
      er_q        <= 1'b0;
      rxd_q       <= '0;
      dv_prev_q   <= 1'b1;
      smp_valid_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      dv_q        <= gmii_rx_dv;
      er_q        <= gmii_rx_er;
      rxd_q       <= gmii_rxd;
      smp_valid_q <= 1'b1;
      // The cleared dv_q straight after reset is not a real sample: keep dv_prev high across it
      // so a frame already running at reset release is not mistaken for a new one.
      dv_prev_q   <= smp_valid_q ? dv_q : 1'b1;
    end
  end

  always_ff @(posedge gmii_rx_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q <= IDLE;
      lane_q  <= '0;
      word_q  <= '0;
      din_q   <= '0;
      wr_en_q <= 1'b0;
      seen_q  <= 1'b0;
      gap_q   <= '0;
      frame_q <= '0;
      drop_q  <= '0;
    end else begin
      wr_en_q <= 1'b0;
      if ((state_q == IDLE || state_q == GAP) && frame_start) begin
        if (STRIP_PREAMBLE) begin
          state_q <= (rxd_q == 8'hD5) ? DATA : PREAMBLE;
        end else begin
          state_q <= DATA;
          word_q  <= word_d;
          lane_q  <= LW'(1);
          seen_q  <= 1'b1;
        end
      end else begin
        case (state_q)
          PREAMBLE: begin
            if (!dv_q) begin
              state_q <= IDLE;
            end else if (er_q) begin
              drop_q  <= drop_q + CNT_W'(1);
              state_q <= DROP;
            end else if (rxd_q == 8'hD5) begin
              state_q <= DATA;
            end else if (rxd_q != 8'h55) begin
              state_q <= DROP;
            end
          end
          DATA: begin
            if (!dv_q) begin
              lane_q <= '0;
              word_q <= '0;
              seen_q <= 1'b0;
              if (lane_q != '0 && full) begin
                drop_q  <= drop_q + CNT_W'(1);
                state_q <= DROP;
              end else begin
                if (lane_q != '0) begin
                  wr_en_q <= 1'b1;
                  din_q   <= word_q;
                end
                if (seen_q) frame_q <= frame_q + CNT_W'(1);
                state_q <= end_state;
                gap_q   <= Gap;
              end
            end else if (er_q) begin
              lane_q  <= '0;
              word_q  <= '0;
              seen_q  <= 1'b0;
              drop_q  <= drop_q + CNT_W'(1);
              state_q <= DROP;
            end else begin
              seen_q <= 1'b1;
              if (lane_q == LAST_LANE) begin
                lane_q <= '0;
                word_q <= '0;
                if (full) begin
                  seen_q  <= 1'b0;
                  drop_q  <= drop_q + CNT_W'(1);
                  state_q <= DROP;
                end else begin
                  wr_en_q <= 1'b1;
                  din_q   <= word_d;
                end
              end else begin
                lane_q <= lane_q + LW'(1);
                word_q <= word_d;
              end
            end
          end
          GAP: begin
            if (!full) begin
              wr_en_q <= 1'b1;
              din_q   <= '0;
              gap_q   <= gap_q - 4'd1;
              if (gap_q == 4'd1) state_q <= IDLE;
            end
          end
          DROP: begin
            if (!dv_q) begin
              state_q <= end_state;
              gap_q   <= Gap;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_gmii2fifo_wide.sv
// Directed bench for gmii2fifo_wide: a scoreboard queue per instance holds the expected FIFO
// words, and a negedge monitor pops and compares them on every write.
module tb_gmii2fifo_wide;
  logic        clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        dv_a = 1'b0, dv_b = 1'b0, er = 1'b0, full = 1'b0;
  logic [7:0]  rxd = '0;
  logic [71:0] din_a, din_b;
  logic        wr_en_a, wr_en_b, wr_clk_a, wr_clk_b;
  logic [15:0] fc_a, dc_a, fc_b, dc_b;

  int          errors = 0, checks = 0, cyc = 0;
  int          exp_fa = 0, exp_da = 0, exp_fb = 0;
  int          a_writes = 0, a_first_wr = 0, t7 = 0;
  bit          use_b = 1'b0;
  logic [71:0] qa[$], qb[$];
  logic [7:0]  frm[$];

  gmii2fifo_wide #(.NBYTES(8), .Gap(4'h2), .STRIP_PREAMBLE(1'b0), .CNT_W(16)) u_dut_a (
    .gmii_rx_clk(clk), .sys_rst(sys_rst), .gmii_rx_dv(dv_a), .gmii_rx_er(er),
    .gmii_rxd(rxd), .full(full), .din(din_a), .wr_en(wr_en_a), .wr_clk(wr_clk_a),
    .frame_cnt(fc_a), .drop_cnt(dc_a));

  gmii2fifo_wide #(.NBYTES(8), .Gap(4'h2), .STRIP_PREAMBLE(1'b1), .CNT_W(16)) u_dut_b (
    .gmii_rx_clk(clk), .sys_rst(sys_rst), .gmii_rx_dv(dv_b), .gmii_rx_er(er),
    .gmii_rxd(rxd), .full(full), .din(din_b), .wr_en(wr_en_b), .wr_clk(wr_clk_b),
    .frame_cnt(fc_b), .drop_cnt(dc_b));

  always #4 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wr_en_a !== 1'b0) begin
      check("a_wr_while_full", 72'(full), 72'd0);
      if (a_writes == 0) a_first_wr = cyc;
      a_writes++;
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL a_extra_write: observed din=%h expected no write", din_a);
      end else begin
        check("a_din", din_a, qa.pop_front());
      end
    end
    if (wr_en_b !== 1'b0) begin
      check("b_wr_while_full", 72'(full), 72'd0);
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL b_extra_write: observed din=%h expected no write", din_b);
      end else begin
        check("b_din", din_b, qb.pop_front());
      end
    end
  end

  task automatic drive(input bit v, input bit e, input logic [7:0] d);
    @(posedge clk);
    #1;
    if (use_b) dv_b = v;
    else dv_a = v;
    er  = e;
    rxd = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic make_frame(input bit pre, input int n);
    frm.delete();
    if (pre) begin
      for (int i = 0; i < 7; i++) frm.push_back(8'h55);
      frm.push_back(8'hD5);
    end
    for (int i = 0; i < n; i++) frm.push_back(8'(i));
  endtask

  task automatic push(input logic [71:0] w);
    if (use_b) qb.push_back(w);
    else qa.push_back(w);
  endtask

  // Word k of an n-byte frame with payload 00,01,...; missing lanes stay 9'h000.
  function automatic logic [71:0] mkword(input int n, input int k);
    logic [71:0] w;
    w = '0;
    for (int l = 0; l < 8; l++)
      if (8*k + l < n) w[9*(7-l) +: 9] = {1'b1, 8'(8*k + l)};
    return w;
  endfunction

  task automatic expect_data(input int n, input int max_words);
    for (int k = 0; k < (n + 7) / 8 && k < max_words; k++) push(mkword(n, k));
  endtask

  task automatic expect_gap(input int n);
    for (int k = 0; k < n; k++) push(72'd0);
  endtask

  task automatic send(input int er_at, input int full_on, input int full_off,
                      input int rst_at, input int rst_off);
    for (int i = 0; i < frm.size(); i++) begin
      drive(1'b1, i == er_at, frm[i]);
      if (i == 7) t7 = cyc;
      if (i == full_on) full = 1'b1;
      if (i == full_off) full = 1'b0;
      if (i == rst_at) begin
        sys_rst = 1'b0;
        #1;
        check("rst_mid_wr_en", 72'(wr_en_a), 72'd0);
        check("rst_mid_din", din_a, 72'd0);
        check("rst_mid_frame_cnt", 72'(fc_a), 72'd0);
        exp_fa = 0;
        exp_da = 0;
      end
      if (i == rst_off) sys_rst = 1'b1;
    end
  endtask

  task automatic end_test(input string tag);
    idle(12);
    check({tag, "_pending"}, 72'(qa.size() + qb.size()), 72'd0);
    check({tag, "_frame_cnt_a"}, 72'(fc_a), 72'(exp_fa));
    check({tag, "_drop_cnt_a"}, 72'(dc_a), 72'(exp_da));
    check({tag, "_frame_cnt_b"}, 72'(fc_b), 72'(exp_fb));
    check({tag, "_drop_cnt_b"}, 72'(dc_b), 72'd0);
  endtask

  task automatic do_reset();
    sys_rst = 1'b0;
    idle(2);
    sys_rst = 1'b1;
    exp_fa = 0;
    exp_da = 0;
    exp_fb = 0;
    qa.delete();
    qb.delete();
    idle(2);
  endtask

  initial begin
    #1 sys_rst = 1'b0;
    #20;
    check("reset_wr_en", 72'(wr_en_a), 72'd0);
    check("reset_din", din_a, 72'd0);
    check("reset_frame_cnt", 72'(fc_a), 72'd0);
    check("reset_drop_cnt", 72'(dc_a), 72'd0);
    sys_rst = 1'b1;
    idle(4);
    #1;
    check("wr_clk_a", 72'(wr_clk_a), 72'(clk));
    check("wr_clk_b", 72'(wr_clk_b), 72'(clk));

    // 64-byte frame: 8 full words, 2 delimiters, write latency of two edges.
    make_frame(1'b0, 64);
    expect_data(64, 8);
    expect_gap(2);
    a_writes = 0;
    send(-1, -1, -1, -1, -1);
    exp_fa = 1;
    end_test("f64");
    check("f64_write_count", 72'(a_writes), 72'd10);
    check("f64_latency", 72'(a_first_wr - t7), 72'd2);

    // 61-byte frame: last word partially filled.
    make_frame(1'b0, 61);
    expect_data(61, 8);
    expect_gap(2);
    send(-1, -1, -1, -1, -1);
    exp_fa = 2;
    end_test("f61");

    // Two-cycle gap between frames truncates the delimiters to one word.
    make_frame(1'b0, 16);
    expect_data(16, 8);
    expect_gap(1);
    send(-1, -1, -1, -1, -1);
    idle(2);
    make_frame(1'b0, 24);
    expect_data(24, 8);
    expect_gap(2);
    send(-1, -1, -1, -1, -1);
    exp_fa = 4;
    end_test("trunc");

    // FIFO full across the third word: frame dropped after two words.
    do_reset();
    make_frame(1'b0, 64);
    expect_data(64, 2);
    expect_gap(2);
    send(-1, 23, 26, -1, -1);
    exp_da = 1;
    end_test("ovf");

    // rx_er at byte 20, then a clean frame.
    do_reset();
    make_frame(1'b0, 64);
    expect_data(64, 2);
    expect_gap(2);
    send(20, -1, -1, -1, -1);
    exp_da = 1;
    end_test("rxer");
    make_frame(1'b0, 16);
    expect_data(16, 8);
    expect_gap(2);
    send(-1, -1, -1, -1, -1);
    exp_fa = 1;
    end_test("rxer_next");

    // Reset in the middle of a frame, released while dv is still high.
    do_reset();
    make_frame(1'b0, 64);
    expect_data(64, 2);
    send(-1, -1, -1, 20, 24);
    end_test("rst_mid");
    make_frame(1'b0, 16);
    expect_data(16, 8);
    expect_gap(2);
    send(-1, -1, -1, -1, -1);
    exp_fa = 1;
    end_test("rst_next");

    // Preamble stripping, then a zero-length frame after the SFD.
    do_reset();
    use_b = 1'b1;
    make_frame(1'b1, 16);
    expect_data(16, 8);
    expect_gap(2);
    send(-1, -1, -1, -1, -1);
    exp_fb = 1;
    end_test("strip");
    make_frame(1'b1, 0);
    expect_gap(2);
    send(-1, -1, -1, -1, -1);
    end_test("strip_empty");
    use_b = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
